// File: rtl/core_pkg.sv
// core_pkg: shared definitions for the core control path.
//   state_t : 3-bit phase encoding driven on core_sequencer.state and
//             consumed by the decode stage.
//   PC_STEP : sequential PC increment (one 32-bit instruction).
package core_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WRITE  = 3'd4,
    IDLE   = 3'd5,
    HALT   = 3'd6
  } state_t;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/seq_pc.sv
// seq_pc: program counter register with next-PC select.
//   clk, rst : clock, synchronous active-high reset (pc <= RESET_PC)
//   en       : advance the PC (asserted in WRITE)
//   take     : branch taken; load tgt instead of pc + PC_STEP
//   tgt      : word-aligned branch target
//   pc       : current PC
module seq_pc
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        take,
  input  logic [31:0] tgt,
  output logic [31:0] pc
);

  // pc + 4 wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst)     pc <= RESET_PC;
    else if (en) pc <= take ? tgt : pc + PC_STEP;
  end

endmodule

// File: rtl/core_sequencer.sv
// core_sequencer: multicycle control FSM for the core.
// Sequences each instruction FETCH -> DECODE -> EXEC -> [MEM] -> WRITE,
// sharing one memory port between instruction fetch and data access.
//   clk, rst        : clock, synchronous active-high reset
//   start           : leave IDLE/HALT and begin fetching
//   state           : current phase (core_pkg::state_t encoding)
//   pc              : address of current instruction
//   mem_req/we      : memory request and write strobe
//   mem_is_data     : address select, 0 = pc, 1 = ALU result
//   mem_ready       : access completes this cycle
//   ir_en           : instruction register load
//   mem_read ... branch_uc : registered decode controls
//   cond_true       : ALU compare result, valid in EXEC
//   branch_target   : ALU-computed target, valid in EXEC
//   halt_req        : stop after the current instruction
//   rf_we           : register-file write enable
//   halted          : high in HALT
//   retired         : retired-instruction count (wraps)
module core_sequencer
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [2:0]  state,
  output logic [31:0] pc,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_is_data,
  input  logic        mem_ready,
  output logic        ir_en,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        reg_write,
  input  logic        branch_c,
  input  logic        branch_uc,
  input  logic        cond_true,
  input  logic [31:0] branch_target,
  input  logic        halt_req,
  output logic        rf_we,
  output logic        halted,
  output logic [31:0] retired
);

  state_t      cur, nxt;
  logic        take;
  logic [31:0] tgt;

  assign state = cur;

  always_ff @(posedge clk) begin
    if (rst) cur <= IDLE;
    else     cur <= nxt;
  end

  // Branch outcome is captured in EXEC so decode inputs and ALU results
  // only need to be valid for that one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      take <= 1'b0;
      tgt  <= RESET_PC;
    end else if (cur == EXEC) begin
      take <= branch_uc | (branch_c & cond_true);
      tgt  <= branch_target & ~32'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                retired <= '0;
    else if (cur == WRITE)  retired <= retired + 32'd1;
  end

  seq_pc #(.RESET_PC(RESET_PC)) u_pc (
    .clk  (clk),
    .rst  (rst),
    .en   (cur == WRITE),
    .take (take),
    .tgt  (tgt),
    .pc   (pc)
  );

  always_comb begin
    nxt         = cur;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_is_data = 1'b0;
    ir_en       = 1'b0;
    rf_we       = 1'b0;
    halted      = 1'b0;
    case (cur)
      FETCH: begin
        mem_req = 1'b1;
        ir_en   = mem_ready;
        if (mem_ready) nxt = DECODE;
      end
      DECODE: nxt = EXEC;
      EXEC:   nxt = (mem_read | mem_write) ? MEM : WRITE;
      MEM: begin
        mem_req     = 1'b1;
        mem_we      = mem_write;
        mem_is_data = 1'b1;
        if (mem_ready) nxt = WRITE;
      end
      WRITE: begin
        rf_we = reg_write;
        nxt   = halt_req ? HALT : FETCH;
      end
      HALT: begin
        halted = 1'b1;
        if (start) nxt = FETCH;
      end
      // IDLE and the unused encoding 7 both behave as IDLE.
      default: nxt = start ? FETCH : IDLE;
    endcase
  end

endmodule
